// File: rtl/mux2_32_bits.sv
// mux2_32_bits: 2:1 word multiplexer for the bus datapath.
//   clk      - system clock, rising edge; clocks only y_q
//   reset_n  - asynchronous active-low reset; clears y_q only
//   d0, d1   - data sources, selected by s = 0 / s = 1
//   s        - select
//   y        - combinational mux result (no storage, no clock/reset dependence)
//   y_q      - registered copy of y, one-cycle latency
module mux2_32_bits #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    // Conditional operator keeps the standard X-merge when s is unknown.
    assign y = s ? d1 : d0;

    // Pipelined copy for registered consumers; no enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_mux2_32_bits.sv
// Self-checking bench for mux2_32_bits: directed plan followed by random traffic.
module tb_mux2_32_bits;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [WIDTH-1:0] exp_q;

    mux2_32_bits #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d0      (d0),
        .d1      (d1),
        .s       (s),
        .y       (y),
        .y_q     (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mask-and-merge with a replicated select.
    function automatic logic [WIDTH-1:0] ref_mux(input logic [WIDTH-1:0] a0,
                                                 input logic [WIDTH-1:0] a1,
                                                 input logic sel);
        logic [WIDTH-1:0] m;
        m = {WIDTH{sel}};
        return (a1 & m) | (a0 & ~m);
    endfunction

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Predict the register, wait one rising edge, compare just after it.
    task automatic tick(input string tag);
        logic [WIDTH-1:0] nxt;
        nxt = reset_n ? ref_mux(d0, d1, s) : '0;
        @(posedge clk);
        #1;
        exp_q = nxt;
        check_val(tag, y_q, exp_q);
    endtask

    task automatic drive(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                         input logic sel, input string tag);
        d0 = a0;
        d1 = a1;
        s  = sel;
        #1;
        check_val(tag, y, ref_mux(d0, d1, s));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_q   = '0;
        reset_n = 1'b0;

        // Combinational path while held in reset
        drive(32'h0000_0000, 32'h0000_0000, 1'b0, "all_zero");
        check_val("all_zero_lit", y, 32'h0000_0000);
        check_val("rst_yq", y_q, 32'h0);
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "sel0_ones");
        check_val("sel0_ones_lit", y, 32'hFFFF_FFFF);
        drive(32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0, "unsel_ignored");
        check_val("unsel_ignored_lit", y, 32'hFFFF_FFFF);
        drive(32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b1, "sel1");
        check_val("sel1_lit", y, 32'hAAAA_AAAA);
        drive(32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b0, "sel_back0");
        check_val("sel_back0_lit", y, 32'hFFFF_FFFF);
        tick("yq_held_in_reset");

        // Release between edges; y_q must wait for the first edge
        drive(32'h0000_0000, 32'h1234_5678, 1'b1, "pre_release");
        reset_n = 1'b1;
        #1;
        check_val("yq_before_edge", y_q, 32'h0);
        tick("yq_first_edge");
        check_val("yq_first_edge_lit", y_q, 32'h1234_5678);

        drive(32'h0F0F_0F0F, 32'h1234_5678, 1'b0, "sw_sel0");
        check_val("yq_not_yet", y_q, 32'h1234_5678);
        tick("yq_next_edge");
        check_val("yq_next_edge_lit", y_q, 32'h0F0F_0F0F);

        // Mid-stream asynchronous reset
        drive(32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b1, "load_aa");
        tick("yq_aa");
        check_val("yq_aa_lit", y_q, 32'hAAAA_AAAA);
        #2;
        reset_n = 1'b0;
        exp_q = '0;
        #1;
        check_val("async_clear", y_q, 32'h0);
        drive(32'h5555_5555, 32'h3C3C_3C3C, 1'b0, "y_during_reset");
        tick("yq_stays_reset");
        reset_n = 1'b1;
        #1;
        check_val("yq_after_release", y_q, 32'h0);
        tick("yq_capture_after_release");

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 300; i++) begin
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), "rnd_y");
            if ($urandom_range(0, 15) == 0) begin
                reset_n = ~reset_n;
                if (!reset_n) exp_q = '0;
                #1;
                check_val("rnd_rst_toggle", y_q, exp_q);
                check_val("rnd_y_rst", y, ref_mux(d0, d1, s));
            end
            drive(d0, WIDTH'($urandom), s, "rnd_y2");
            tick("rnd_yq");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
